controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 25 ++
 rtl/controller.sv | 83 ++++++++
 tb/tb_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/controller_pkg.sv
// Shared types and constants for the thermostat controller: state encoding,
// default thresholds and fan speed codes.
package controller_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HEAT  = 3'd1,
        COOL4 = 3'd2,
        COOL6 = 3'd3,
        COOL8 = 3'd4
    } state_t;

    localparam logic signed [7:0] DEF_HEAT_ON  = 8'sd15;
    localparam logic signed [7:0] DEF_HEAT_OFF = 8'sd30;
    localparam logic signed [7:0] DEF_COOL_ON  = 8'sd35;
    localparam logic signed [7:0] DEF_COOL_OFF = 8'sd25;
    localparam logic signed [7:0] DEF_FAN_MID  = 8'sd40;
    localparam logic signed [7:0] DEF_FAN_HIGH = 8'sd45;

    localparam logic [3:0] RPS_OFF  = 4'd0;
    localparam logic [3:0] RPS_LOW  = 4'd4;
    localparam logic [3:0] RPS_MID  = 4'd6;
    localparam logic [3:0] RPS_HIGH = 4'd8;

endpackage

// File: rtl/controller.sv
// Moore thermostat FSM: heater with hysteresis plus a three-speed cooler fan,
// one state step per clock, outputs registered alongside the state.
module controller
    import controller_pkg::*;
#(
    parameter logic signed [7:0] HEAT_ON  = DEF_HEAT_ON,
    parameter logic signed [7:0] HEAT_OFF = DEF_HEAT_OFF,
    parameter logic signed [7:0] COOL_ON  = DEF_COOL_ON,
    parameter logic signed [7:0] COOL_OFF = DEF_COOL_OFF,
    parameter logic signed [7:0] FAN_MID  = DEF_FAN_MID,
    parameter logic signed [7:0] FAN_HIGH = DEF_FAN_HIGH
) (
    input  logic signed [7:0] sensor,
    input  logic              clock,
    input  logic              reset,
    output logic              cooler,
    output logic              heater,
    output logic [3:0]        rps
);

    state_t     state_q, state_d;
    logic       cooler_q, cooler_d;
    logic       heater_q, heater_d;
    logic [3:0] rps_q, rps_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sensor < HEAT_ON)      state_d = HEAT;
                else if (sensor > COOL_ON) state_d = COOL4;
            end
            HEAT: begin
                if (sensor > HEAT_OFF)     state_d = IDLE;
            end
            COOL4: begin
                if (sensor > FAN_MID)       state_d = COOL6;
                else if (sensor < COOL_OFF) state_d = IDLE;
            end
            COOL6: begin
                if (sensor > FAN_HIGH)     state_d = COOL8;
                else if (sensor < COOL_ON) state_d = COOL4;
            end
            COOL8: begin
                if (sensor < FAN_MID)      state_d = COOL6;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the output flops always mirror state_q.
    always_comb begin
        cooler_d = 1'b0;
        heater_d = 1'b0;
        rps_d    = RPS_OFF;
        case (state_d)
            HEAT:  heater_d = 1'b1;
            COOL4: begin cooler_d = 1'b1; rps_d = RPS_LOW;  end
            COOL6: begin cooler_d = 1'b1; rps_d = RPS_MID;  end
            COOL8: begin cooler_d = 1'b1; rps_d = RPS_HIGH; end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cooler_q <= 1'b0;
            heater_q <= 1'b0;
            rps_q    <= RPS_OFF;
        end else begin
            state_q  <= state_d;
            cooler_q <= cooler_d;
            heater_q <= heater_d;
            rps_q    <= rps_d;
        end
    end

    assign cooler = cooler_q;
    assign heater = heater_q;
    assign rps    = rps_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the thermostat controller; expected outputs are hand-derived
// from the transition table.
module tb_controller;

    logic signed [7:0] sensor;
    logic              clock;
    logic              reset;
    logic              cooler;
    logic              heater;
    logic [3:0]        rps;

    int checks = 0;
    int errors = 0;

    controller dut (
        .sensor (sensor),
        .clock  (clock),
        .reset  (reset),
        .cooler (cooler),
        .heater (heater),
        .rps    (rps)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic c, input logic h, input logic [3:0] r);
        checks++;
        assert ({cooler, heater, rps} === {c, h, r})
        else begin
            errors++;
            $error("FAIL %s: observed cooler=%0b heater=%0b rps=%0d, expected cooler=%0b heater=%0b rps=%0d",
                   tag, cooler, heater, rps, c, h, r);
        end
        checks++;
        assert (!(cooler === 1'b1 && heater === 1'b1) && (cooler === 1'b1 || rps === 4'd0))
        else begin
            errors++;
            $error("FAIL %s_excl: observed cooler=%0b heater=%0b rps=%0d, expected exclusive outputs",
                   tag, cooler, heater, rps);
        end
    endtask

    task automatic step(input logic signed [7:0] v);
        @(negedge clock);
        sensor = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        sensor = 8'sd20;
        #2;
        check("reset_immediate", 1'b0, 1'b0, 4'd0);
        @(posedge clock); #1;
        check("reset_held", 1'b0, 1'b0, 4'd0);
        @(negedge clock);
        reset = 1'b0;

        step(8'sd20);  check("idle_20_a", 1'b0, 1'b0, 4'd0);
        step(8'sd20);  check("idle_20_b", 1'b0, 1'b0, 4'd0);

        step(8'sd40);  check("idle_to_cool4", 1'b1, 1'b0, 4'd4);
        step(8'sd40);  check("cool4_eq_fanmid", 1'b1, 1'b0, 4'd4);
        step(8'sd25);  check("cool4_eq_cooloff", 1'b1, 1'b0, 4'd4);
        step(8'sd20);  check("cool4_to_idle", 1'b0, 1'b0, 4'd0);

        step(8'sd8);   check("idle_to_heat", 1'b0, 1'b1, 4'd0);
        step(8'sd30);  check("heat_eq_heatoff", 1'b0, 1'b1, 4'd0);
        step(8'sd33);  check("heat_to_idle", 1'b0, 1'b0, 4'd0);
        step(8'sd15);  check("idle_eq_heaton", 1'b0, 1'b0, 4'd0);
        step(8'sd35);  check("idle_eq_coolon", 1'b0, 1'b0, 4'd0);
        step(-8'sd5);  check("idle_neg_heat", 1'b0, 1'b1, 4'd0);

        step(8'sd46);  check("heat_46_idle", 1'b0, 1'b0, 4'd0);
        step(8'sd46);  check("idle_46_cool4", 1'b1, 1'b0, 4'd4);
        step(8'sd46);  check("cool4_46_cool6", 1'b1, 1'b0, 4'd6);
        step(8'sd46);  check("cool6_46_cool8", 1'b1, 1'b0, 4'd8);
        step(8'sd42);  check("cool8_42_stay", 1'b1, 1'b0, 4'd8);
        step(8'sd40);  check("cool8_eq_fanmid", 1'b1, 1'b0, 4'd8);
        step(8'sd38);  check("cool8_to_cool6", 1'b1, 1'b0, 4'd6);
        step(8'sd45);  check("cool6_eq_fanhigh", 1'b1, 1'b0, 4'd6);
        step(8'sd35);  check("cool6_eq_coolon", 1'b1, 1'b0, 4'd6);
        step(8'sd30);  check("cool6_to_cool4", 1'b1, 1'b0, 4'd4);
        step(8'sd24);  check("cool4_24_idle", 1'b0, 1'b0, 4'd0);

        step(8'sd46);  check("rst_seq_cool4", 1'b1, 1'b0, 4'd4);
        step(8'sd46);  check("rst_seq_cool6", 1'b1, 1'b0, 4'd6);
        step(8'sd46);  check("rst_seq_cool8", 1'b1, 1'b0, 4'd8);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_cool8", 1'b0, 1'b0, 4'd0);
        @(posedge clock); #1;
        check("reset_holds_idle", 1'b0, 1'b0, 4'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_first_edge", 1'b1, 1'b0, 4'd4);
        step(8'sd20);  check("post_reset_back_idle", 1'b0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
